// File: rtl/ccg_bist_harness.sv
// ccg_bist_harness: LFSR pattern source plus MISR compactor for one combinational netlist.
// The optional golden-response comparator is enabled by defining CCG_BIST_COMPARE_EN.
module ccg_bist_harness #(
  parameter int                N_IN      = 25,
  parameter int                N_OUT     = 17,
  parameter int                N_PAT     = 256,
  parameter int                LFSR_W    = 32,
  parameter logic [LFSR_W-1:0] LFSR_POLY = 32'hA3000000,
  parameter logic [LFSR_W-1:0] SEED      = 32'h0000_0001,
  parameter int                SIG_W     = 32,
  parameter logic [SIG_W-1:0]  MISR_POLY = 32'h04C11DB7,
  parameter logic [SIG_W-1:0]  MISR_SEED = 32'h0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [SIG_W-1:0] exp_sig,
  output logic [N_IN-1:0]  dut_in,
  input  logic [N_OUT-1:0] dut_out,
`ifdef CCG_BIST_COMPARE_EN
  input  logic [N_OUT-1:0] exp_out,
  output logic [15:0]      mism_cnt,
  output logic [15:0]      first_fail,
`endif
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature,
  output logic [15:0]      pat_cnt
);
  if (SEED == '0) begin : g_bad_seed
    $error("ccg_bist_harness: SEED must be nonzero");
  end
  if (N_IN < 1 || N_IN > LFSR_W || N_OUT < 1 || N_OUT > SIG_W || N_PAT < 1 || N_PAT > 65535) begin : g_bad_size
    $error("ccg_bist_harness: parameter out of range");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t            state;
  logic [LFSR_W-1:0] lfsr, lfsr_nxt;
  logic [SIG_W-1:0]  misr, misr_nxt;
  logic              last, sig_ok;
  assign dut_in    = lfsr[N_IN-1:0];
  assign signature = misr;
  assign lfsr_nxt  = (lfsr >> 1) ^ (lfsr[0] ? LFSR_POLY : '0);
  assign misr_nxt  = (misr << 1) ^ (misr[SIG_W-1] ? MISR_POLY : '0) ^ SIG_W'(dut_out);
  assign last      = (pat_cnt + 16'd1) == 16'(N_PAT);
`ifdef CCG_BIST_COMPARE_EN
  logic        mism;
  logic [15:0] mism_nxt;
  assign mism     = dut_out != exp_out;
  assign mism_nxt = mism_cnt + 16'(mism && !(&mism_cnt));
  assign sig_ok   = (misr_nxt == exp_sig) && (mism_nxt == 16'd0);
`else
  assign sig_ok   = misr_nxt == exp_sig;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      lfsr    <= SEED;
      misr    <= MISR_SEED;
      pat_cnt <= 16'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
`ifdef CCG_BIST_COMPARE_EN
      mism_cnt   <= 16'd0;
      first_fail <= 16'hFFFF;
`endif
    end else if (start && state != RUN) begin
      state   <= RUN;
      lfsr    <= SEED;
      misr    <= MISR_SEED;
      pat_cnt <= 16'd0;
      busy    <= 1'b1;
      done    <= 1'b0;
      pass    <= 1'b0;
`ifdef CCG_BIST_COMPARE_EN
      mism_cnt   <= 16'd0;
      first_fail <= 16'hFFFF;
`endif
    end else if (state == RUN) begin
      lfsr    <= lfsr_nxt;
      misr    <= misr_nxt;
      pat_cnt <= pat_cnt + 16'd1;
`ifdef CCG_BIST_COMPARE_EN
      mism_cnt <= mism_nxt;
      if (mism && first_fail == 16'hFFFF) first_fail <= pat_cnt;
`endif
      if (last) begin
        state <= DONE;
        busy  <= 1'b0;
        done  <= 1'b1;
        pass  <= sig_ok;
      end
    end
  end
endmodule

// File: tb/tb_ccg_bist_harness.sv
// tb_ccg_bist_harness: directed scoreboard bench for ccg_bist_harness (N_PAT=4 loopback and N_PAT=256 tied-zero instances).
module tb_ccg_bist_harness;
  logic        clk = 0, rst_n = 0, start4 = 0, startz = 0;
  logic [31:0] exp_sig4 = 0, exp_sigz = 0;
  logic [24:0] din4, dinz;
  logic [16:0] dout4, doutz;
  logic        busy4, done4, pass4, busyz, donez, passz;
  logic [31:0] sig4, sigz;
  logic [15:0] pc4, pcz;
  int          passed = 0, total = 0;
  logic [31:0] din_q[$];
  logic [31:0] sig_q[$];
  assign dout4 = din4[16:0];
  assign doutz = 17'h0;
`ifdef CCG_BIST_COMPARE_EN
  logic        flip = 0;
  logic [16:0] eout4, eoutz;
  logic [15:0] mc4, ff4, mcz, ffz;
  assign eout4 = dout4;
  assign eoutz = (flip && (pcz == 16'd5 || pcz == 16'd9)) ? 17'h8 : 17'h0;
`endif
  always #5 clk = ~clk;

  ccg_bist_harness #(.N_PAT(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .exp_sig(exp_sig4), .dut_in(din4), .dut_out(dout4),
`ifdef CCG_BIST_COMPARE_EN
    .exp_out(eout4), .mism_cnt(mc4), .first_fail(ff4),
`endif
    .busy(busy4), .done(done4), .pass(pass4), .signature(sig4), .pat_cnt(pc4));

  ccg_bist_harness #(.N_PAT(256)) uz (
    .clk(clk), .rst_n(rst_n), .start(startz), .exp_sig(exp_sigz), .dut_in(dinz), .dut_out(doutz),
`ifdef CCG_BIST_COMPARE_EN
    .exp_out(eoutz), .mism_cnt(mcz), .first_fail(ffz),
`endif
    .busy(busyz), .done(donez), .pass(passz), .signature(sigz), .pat_cnt(pcz));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Independent reference: loopback dut_out = lfsr[16:0] from the default seed.
  function automatic logic [31:0] model_sig(input int n);
    logic [31:0] l, m;
    l = 32'h1;
    m = 32'h0;
    for (int i = 0; i < n; i++) begin
      m = (m << 1) ^ (m[31] ? 32'h04C11DB7 : 32'h0) ^ {15'h0, l[16:0]};
      l = (l >> 1) ^ (l[0] ? 32'hA3000000 : 32'h0);
    end
    return m;
  endfunction

  task automatic run4(input logic [31:0] es, input logic hold);
    int cyc;
    logic [31:0] e;
    din_q.push_back(32'h0000001);
    din_q.push_back(32'h1000000);
    din_q.push_back(32'h1800000);
    din_q.push_back(32'h0C00000);
    sig_q.push_back(model_sig(4));
    exp_sig4 = es;
    start4 = 1;
    @(negedge clk);
    start4 = hold;
    check("busy_rise4", {31'h0, busy4}, 32'h1);
    check("done_drop4", {31'h0, done4}, 32'h0);
    cyc = 0;
    while (busy4 && cyc < 20) begin
      if (din_q.size() > 0) check("dut_in4", {7'h0, din4}, din_q.pop_front());
      @(negedge clk);
      cyc++;
    end
    start4 = 0;
    e = sig_q.pop_front();
    check("run_len4", cyc, 32'd4);
    check("din_q_left", din_q.size(), 32'd0);
    check("done4", {31'h0, done4}, 32'h1);
    check("sig4", sig4, e);
    check("pass4", {31'h0, pass4}, {31'h0, e == es});
    check("pat_cnt4", {16'h0, pc4}, 32'd4);
  endtask

  task automatic runz(input logic flip_en);
    int cyc;
`ifdef CCG_BIST_COMPARE_EN
    flip = flip_en;
`endif
    sig_q.push_back(32'h0);
    startz = 1;
    @(negedge clk);
    startz = 0;
    cyc = 0;
    while (busyz && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check("run_lenz", cyc, 32'd256);
    check("donez", {31'h0, donez}, 32'h1);
    check("sigz", sigz, sig_q.pop_front());
    check("pat_cntz", {16'h0, pcz}, 32'd256);
`ifdef CCG_BIST_COMPARE_EN
    check("passz", {31'h0, passz}, {31'h0, !flip_en});
    check("mism_cnt", {16'h0, mcz}, flip_en ? 32'd2 : 32'd0);
    check("first_fail", {16'h0, ffz}, flip_en ? 32'd5 : 32'hFFFF);
    flip = 0;
`else
    check("passz", {31'h0, passz}, {31'h0, !flip_en});
`endif
  endtask

  initial begin
    logic [31:0] ms;
    ms = model_sig(4);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("rst_busy", {31'h0, busy4}, 32'h0);
    check("rst_done", {31'h0, done4}, 32'h0);
    check("rst_pass", {31'h0, pass4}, 32'h0);
    check("rst_pat_cnt", {16'h0, pc4}, 32'h0);
    check("rst_dut_in", {7'h0, din4}, 32'h1);
    check("rst_sig", sig4, 32'h0);
    run4(ms, 1'b0);
    run4(ms ^ 32'h1, 1'b0);
    run4(ms, 1'b1);
    run4(ms, 1'b0);
    runz(1'b0);
    startz = 1;
    @(negedge clk);
    startz = 0;
    repeat (10) @(negedge clk);
    check("mid_busy", {31'h0, busyz}, 32'h1);
    rst_n = 0;
    #1;
    check("arst_busy", {31'h0, busyz}, 32'h0);
    check("arst_done", {31'h0, donez}, 32'h0);
    check("arst_pat_cnt", {16'h0, pcz}, 32'h0);
    check("arst_dut_in", {7'h0, dinz}, 32'h1);
    check("arst_sig", sigz, 32'h0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    runz(1'b0);
`ifdef CCG_BIST_COMPARE_EN
    runz(1'b1);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
